// File: rtl/teraisc_ab_pkg.sv
// Shared definitions for the quadrature A/B phase generator: phase codes, FSM states,
// default widths and the Gray-step helper.
package teraisc_ab_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_DIV_W = 16;
  localparam int unsigned DEF_POS_W = 32;
  localparam int unsigned DEF_CPR   = 4096;

  // Phase codes are {A, B}
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // dir=1 walks 00->01->11->10 (B leads A); dir=0 walks the reverse cycle
  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic dir);
    logic [1:0] nxt;
    nxt = ab;
    unique case (ab)
      AB_00: nxt = dir ? AB_01 : AB_10;
      AB_01: nxt = dir ? AB_11 : AB_00;
      AB_11: nxt = dir ? AB_10 : AB_01;
      AB_10: nxt = dir ? AB_00 : AB_11;
      default: nxt = AB_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/teraisc_ab_encoder_if.sv
// Command and phase-output bundle of the quadrature A/B phase generator.
// master = commanding side, slave = the encoder.
interface teraisc_ab_encoder_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned POS_W = 32
);

  logic             DI_CMD_VALID;
  logic             DO_CMD_READY;
  logic [CNT_W-1:0] DI_CMD_COUNT;
  logic             DI_CMD_DIR;
  logic [DIV_W-1:0] DI_CMD_PERIOD;
  logic             DI_ABORT;
  logic             DO_PHASE_A;
  logic             DO_PHASE_B;
  logic             DO_PHASE_Z;
  logic             DO_BUSY;
  logic             DO_DONE;
  logic [POS_W-1:0] DO_POSITION;

  modport master (
    output DI_CMD_VALID, DI_CMD_COUNT, DI_CMD_DIR, DI_CMD_PERIOD, DI_ABORT,
    input  DO_CMD_READY, DO_PHASE_A, DO_PHASE_B, DO_PHASE_Z, DO_BUSY, DO_DONE, DO_POSITION
  );

  modport slave (
    input  DI_CMD_VALID, DI_CMD_COUNT, DI_CMD_DIR, DI_CMD_PERIOD, DI_ABORT,
    output DO_CMD_READY, DO_PHASE_A, DO_PHASE_B, DO_PHASE_Z, DO_BUSY, DO_DONE, DO_POSITION
  );

endinterface

// File: rtl/teraisc_ab_rate_timer.sv
// Loadable edge-interval down-counter: after a load, ticks once every period clocks while
// enabled. A period of 0 behaves as 1.
module teraisc_ab_rate_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] per_q;
  logic [DIV_W-1:0] per_eff;

  assign per_eff = (period == '0) ? DIV_W'(1) : period;
  assign tick    = enable && !clear && (cnt_q == DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      per_q <= '0;
    end else if (load) begin
      cnt_q <= per_eff;
      per_q <= per_eff;
    end else if (tick) begin
      cnt_q <= per_q;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/teraisc_ab_encoder.sv
// Quadrature A/B phase generator with signed position tracking.
// Optional index output enabled by defining TERAISC_AB_ENCODER_INDEX_EN.
module teraisc_ab_encoder
  import teraisc_ab_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned POS_W = DEF_POS_W,
  parameter int unsigned CPR   = DEF_CPR
) (
  input logic DI_SYSCLK,
  input logic DI_RESET,
  teraisc_ab_encoder_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       ab_q, ab_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept, load, clear, enable, tick;

  assign accept = bus.DI_CMD_VALID && ready_q;
  assign enable = (state_q == RUN) && (rem_q != '0);

  teraisc_ab_rate_timer #(
    .DIV_W (DIV_W)
  ) u_rate_timer (
    .clk    (DI_SYSCLK),
    .rst    (DI_RESET),
    .load   (load),
    .clear  (clear),
    .enable (enable),
    .period (bus.DI_CMD_PERIOD),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    ab_d    = ab_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.DI_CMD_COUNT == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = bus.DI_CMD_COUNT;
            dir_d   = bus.DI_CMD_DIR;
            load    = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // rem_q==0 is the cycle DONE is showing; READY follows one cycle later
        if (rem_q == '0) begin
          state_d = IDLE;
        end else if (bus.DI_ABORT) begin
          state_d = IDLE;
          done_d  = 1'b1;
          clear   = 1'b1;
        end else if (tick) begin
          ab_d   = next_phase(ab_q, dir_q);
          pos_d  = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          rem_d  = rem_q - CNT_W'(1);
          done_d = (rem_q == CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
  end

  always_ff @(posedge DI_SYSCLK) begin
    if (DI_RESET) begin
      state_q <= IDLE;
      ab_q    <= AB_00;
      pos_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.DO_CMD_READY = ready_q;
  assign bus.DO_PHASE_A   = ab_q[1];
  assign bus.DO_PHASE_B   = ab_q[0];
  assign bus.DO_BUSY      = busy_q;
  assign bus.DO_DONE      = done_q;
  assign bus.DO_POSITION  = pos_q;

`ifdef TERAISC_AB_ENCODER_INDEX_EN
  logic z_q, z_d;

  // CPR is a power of two, so the modulo reduces to a mask
  assign z_d = ((pos_d & POS_W'(CPR - 1)) == '0) && (ab_d == AB_00);

  always_ff @(posedge DI_SYSCLK) begin
    if (DI_RESET) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  assign bus.DO_PHASE_Z = z_q;
`else
  assign bus.DO_PHASE_Z = 1'b0;
`endif

endmodule

// File: tb/tb_teraisc_ab_encoder.sv
// Bench for teraisc_ab_encoder: cycle-level reference model checked every cycle plus
// literal expectations for the directed scenarios.
module tb_teraisc_ab_encoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  teraisc_ab_encoder_if #(.CNT_W(16), .DIV_W(16), .POS_W(32)) bus ();

  teraisc_ab_encoder #(
    .CNT_W (16),
    .DIV_W (16),
    .POS_W (32),
    .CPR   (8)
  ) dut (
    .DI_SYSCLK (clk),
    .DI_RESET  (rst),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: phase as an index into the dir=1 sequence, edges scheduled by cycle number
  bit          m_run, m_ready, m_busy, m_done, m_dir;
  int          m_idx, m_rem, m_per, m_next;
  logic [31:0] m_pos;

  // Looped-back quadrature decoder on the DUT outputs
  logic [1:0] prev_ab;
  int         dec_pos, dec_last;

  function automatic logic [1:0] ab_of(input int i);
    logic [1:0] r;
    case (i)
      0: r = 2'b00;
      1: r = 2'b01;
      2: r = 2'b11;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  function automatic int idx_of(input logic [1:0] ab);
    int r;
    case (ab)
      2'b00: r = 0;
      2'b01: r = 1;
      2'b11: r = 2;
      default: r = 3;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int c, input bit d, input int p, input bit ab);
    bus.DI_CMD_VALID  = v;
    bus.DI_CMD_COUNT  = 16'(c);
    bus.DI_CMD_DIR    = d;
    bus.DI_CMD_PERIOD = 16'(p);
    bus.DI_ABORT      = ab;
  endtask

  task automatic tick(output bit acc);
    bit   r, v, d, ab, z_exp;
    int   c, p, delta;
    logic [1:0] cur;
    r  = rst;
    v  = bus.DI_CMD_VALID;
    c  = int'(bus.DI_CMD_COUNT);
    d  = bus.DI_CMD_DIR;
    p  = int'(bus.DI_CMD_PERIOD);
    ab = bus.DI_ABORT;
    acc = !r && v && m_ready;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_run = 0; m_ready = 0; m_busy = 0; m_done = 0; m_idx = 0; m_pos = '0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (acc) begin
          if (c == 0) begin
            m_done = 1;
          end else begin
            m_run  = 1;
            m_rem  = c;
            m_dir  = d;
            m_per  = (p == 0) ? 1 : p;
            m_next = cyc + m_per;
          end
        end
      end else if (m_rem == 0) begin
        m_run = 0;
      end else if (ab) begin
        m_run  = 0;
        m_done = 1;
      end else if (cyc == m_next) begin
        m_idx  = m_dir ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
        m_pos  = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
        m_rem  = m_rem - 1;
        m_next = m_next + m_per;
        if (m_rem == 0) m_done = 1;
      end
      m_ready = !m_run;
      m_busy  = m_run;
    end
`ifdef TERAISC_AB_ENCODER_INDEX_EN
    z_exp = !r && (m_pos[2:0] == 3'b000) && (m_idx == 0);
`else
    z_exp = 1'b0;
`endif
    #1;
    chk("ab", {bus.DO_PHASE_A, bus.DO_PHASE_B}, ab_of(m_idx));
    chk("position", bus.DO_POSITION, m_pos);
    chk("done", bus.DO_DONE, m_done);
    chk("ready", bus.DO_CMD_READY, m_ready);
    chk("busy", bus.DO_BUSY, m_busy);
    chk("z", bus.DO_PHASE_Z, z_exp);
    cur = {bus.DO_PHASE_A, bus.DO_PHASE_B};
    if (!r && cur != prev_ab) begin
      delta = (idx_of(cur) - idx_of(prev_ab) + 4) % 4;
      if (delta == 1) begin dec_pos++; dec_last = 1; end
      else if (delta == 3) begin dec_pos--; dec_last = -1; end
    end
    prev_ab = cur;
  endtask

  task automatic ticks(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(2);
  endtask

  logic [1:0] ab_h[0:15];
  bit         done_h[0:15];
  bit         ready_h[0:15];
  bit         acc, busy_seen, zany;
  int         waited, z8, z16, zother;
  logic [31:0] pos_now;

  initial begin
    prev_ab = 2'b00; dec_pos = 0; dec_last = 0;
    m_run = 0; m_ready = 0; m_busy = 0; m_done = 0; m_idx = 0; m_pos = '0;
    m_dir = 0; m_rem = 0; m_per = 1; m_next = 0;
    zany = 0;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    ticks(3);
    chk("reset_ready", bus.DO_CMD_READY, 1'b0);
    chk("reset_pos", bus.DO_POSITION, 32'd0);
    rst = 1'b0;
    ticks(2);

    // 1: COUNT=4 DIR=1 PERIOD=3
    drive(1, 4, 1, 3, 0);
    tick(acc);
    chk("t1_accept", acc, 1'b1);
    drive(0, 0, 0, 0, 0);
    dec_pos = 0;
    for (int i = 1; i <= 13; i++) begin
      tick(acc);
      ab_h[i]    = {bus.DO_PHASE_A, bus.DO_PHASE_B};
      done_h[i]  = bus.DO_DONE;
      ready_h[i] = bus.DO_CMD_READY;
    end
    chk("t1_ab2", ab_h[2], 2'b00);
    chk("t1_ab3", ab_h[3], 2'b01);
    chk("t1_ab6", ab_h[6], 2'b11);
    chk("t1_ab9", ab_h[9], 2'b10);
    chk("t1_ab12", ab_h[12], 2'b00);
    chk("t1_done11", done_h[11], 1'b0);
    chk("t1_done12", done_h[12], 1'b1);
    chk("t1_ready12", ready_h[12], 1'b0);
    chk("t1_ready13", ready_h[13], 1'b1);
    chk("t1_pos", bus.DO_POSITION, 32'd4);
    chk("t1_dec_pos", 64'(dec_pos), 64'd4);
    chk("t1_dec_dir", 64'(dec_last), 64'd1);

    // 2: PERIOD=0 acts as 1, DIR=0
    do_reset();
    drive(1, 2, 0, 0, 0);
    tick(acc);
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(acc);
      ab_h[i]   = {bus.DO_PHASE_A, bus.DO_PHASE_B};
      done_h[i] = bus.DO_DONE;
    end
    chk("t2_ab1", ab_h[1], 2'b10);
    chk("t2_ab2", ab_h[2], 2'b11);
    chk("t2_done2", done_h[2], 1'b1);
    chk("t2_pos", bus.DO_POSITION, 32'hFFFF_FFFE);

    // 3: COUNT=0
    drive(1, 0, 1, 5, 0);
    tick(acc);
    chk("t3_accept", acc, 1'b1);
    chk("t3_done0", bus.DO_DONE, 1'b1);
    busy_seen = bus.DO_BUSY;
    drive(0, 0, 0, 0, 0);
    tick(acc);
    chk("t3_done1", bus.DO_DONE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      busy_seen = busy_seen | bus.DO_BUSY;
    end
    chk("t3_busy", busy_seen, 1'b0);
    chk("t3_ab", {bus.DO_PHASE_A, bus.DO_PHASE_B}, 2'b11);
    chk("t3_pos", bus.DO_POSITION, 32'hFFFF_FFFE);

    // 4: abort on the third edge cycle
    do_reset();
    drive(1, 10, 1, 2, 0);
    tick(acc);
    drive(0, 0, 0, 0, 0);
    ticks(5);
    bus.DI_ABORT = 1'b1;
    tick(acc);
    bus.DI_ABORT = 1'b0;
    chk("t4_done", bus.DO_DONE, 1'b1);
    chk("t4_ready", bus.DO_CMD_READY, 1'b1);
    chk("t4_ab", {bus.DO_PHASE_A, bus.DO_PHASE_B}, 2'b11);
    chk("t4_pos", bus.DO_POSITION, 32'd2);
    tick(acc);
    chk("t4_done_gone", bus.DO_DONE, 1'b0);
    ticks(4);
    chk("t4_ab_hold", {bus.DO_PHASE_A, bus.DO_PHASE_B}, 2'b11);
    bus.DI_ABORT = 1'b1;
    tick(acc);
    bus.DI_ABORT = 1'b0;
    chk("t4_idle_abort", bus.DO_DONE, 1'b0);

    // 5: second command held during RUN
    drive(1, 3, 1, 2, 0);
    tick(acc);
    drive(1, 2, 0, 1, 0);
    waited = 0;
    acc = 0;
    while (!acc && waited < 40) begin
      tick(acc);
      waited++;
    end
    chk("t5_accepted", acc, 1'b1);
    chk("t5_wait", 64'(waited), 64'd8);
    drive(0, 0, 0, 0, 0);
    ticks(6);
    chk("t5_ab", {bus.DO_PHASE_A, bus.DO_PHASE_B}, 2'b10);
    chk("t5_pos", bus.DO_POSITION, 32'd3);

    // Reset during RUN
    drive(1, 50, 1, 1, 0);
    tick(acc);
    drive(0, 0, 0, 0, 0);
    ticks(5);
    rst = 1'b1;
    tick(acc);
    chk("rst_ab", {bus.DO_PHASE_A, bus.DO_PHASE_B}, 2'b00);
    chk("rst_pos", bus.DO_POSITION, 32'd0);
    chk("rst_busy", bus.DO_BUSY, 1'b0);
    rst = 1'b0;
    ticks(2);

    // 6: index pulse
    zany = bus.DO_PHASE_Z;
`ifdef TERAISC_AB_ENCODER_INDEX_EN
    chk("t6_z_prestart", bus.DO_PHASE_Z, 1'b1);
`endif
    drive(1, 16, 1, 1, 0);
    tick(acc);
    drive(0, 0, 0, 0, 0);
    z8 = 0; z16 = 0; zother = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(acc);
      pos_now = bus.DO_POSITION;
      zany = zany | bus.DO_PHASE_Z;
      if (bus.DO_PHASE_Z) begin
        if (pos_now == 32'd8) z8++;
        else if (pos_now == 32'd16) z16++;
        else zother++;
      end
    end
    chk("t6_pos", bus.DO_POSITION, 32'd16);
`ifdef TERAISC_AB_ENCODER_INDEX_EN
    chk("t6_z8", 64'(z8), 64'd1);
    chk("t6_z16", 64'(z16), 64'd5);
    chk("t6_zother", 64'(zother), 64'd0);
`else
    chk("t6_z_tied", zany, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
